mem_stage: RTL

Memory-access stage of the RISC-V pipeline, between EX and WB. It accepts one instruction at a time from EX over a valid/ready handshake and performs any load or store on the data-memory port. Data-memory requests are held until acknowledged, and load data is extended by width and sign. Each result is presented to WB as one registered bundle.

---
 rtl/mem_stage.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access stage between EX and WB: issues one load/store at a time on a
// req/ack data-memory port and hands a registered result bundle to WB.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic        MemtoReg,
  input  logic        RegWr,
  input  logic        done,
  input  logic [2:0]  funct3,
  input  logic [4:0]  Rd,
  input  logic [31:0] ALUout,
  input  logic [31:0] Rs2data,
  input  logic [31:0] currentPC,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        MemtoReg_o,
  output logic        RegWr_o,
  output logic        done_o,
  output logic        misalign_o,
  output logic [4:0]  Rd_o,
  output logic [31:0] Do,
  output logic [31:0] ALUout_o,
  output logic [31:0] PC_o,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_e;

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic        m2r_q, m2r_d, regwr_q, regwr_d, done_q, done_d, mis_q, mis_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] do_q, do_d, alu_q, alu_d, pc_q, pc_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic [2:0]  f3_q, f3_d;

  logic        accept, mem_op, misaligned;
  logic [1:0]  lane;
  logic [3:0]  st_mask;
  logic [31:0] st_wdata, ld_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // funct3[1] set means word access; this also covers the unlisted codes treated as LW
  always_comb begin
    lane       = ALUout[1:0];
    mem_op     = MemRd | MemWr;
    misaligned = funct3[1] ? (lane != 2'b00) : (funct3[0] & lane[0]);
    if (funct3[1]) begin
      st_mask  = 4'b1111;
      st_wdata = Rs2data;
    end else if (funct3[0]) begin
      st_mask  = 4'b0011 << {lane[1], 1'b0};
      st_wdata = {2{Rs2data[15:0]}};
    end else begin
      st_mask  = 4'b0001 << lane;
      st_wdata = {4{Rs2data[7:0]}};
    end
  end

  always_comb begin
    case (alu_q[1:0])
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = alu_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    m2r_d   = m2r_q;
    regwr_d = regwr_q;
    done_d  = done_q;
    mis_d   = mis_q;
    rd_d    = rd_q;
    do_d    = do_q;
    alu_d   = alu_q;
    pc_d    = pc_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;

    in_ready = (state_q == IDLE) && (!valid_q || out_ready) && !flush;
    accept   = in_valid && in_ready;

    if (valid_q && out_ready) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          m2r_d   = MemtoReg;
          regwr_d = RegWr;
          done_d  = done;
          rd_d    = Rd;
          alu_d   = ALUout;
          pc_d    = currentPC;
          f3_d    = funct3;
          do_d    = '0;
          mis_d   = 1'b0;
          if (mem_op && misaligned) begin
            mis_d   = 1'b1;
            regwr_d = 1'b0;
            valid_d = 1'b1;
          end else if (mem_op) begin
            req_d   = 1'b1;
            we_d    = MemWr;
            addr_d  = {ALUout[31:2], 2'b00};
            mask_d  = st_mask;
            wdata_d = st_wdata;
            state_d = WAIT;
          end else begin
            valid_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = IDLE;
          if (!flush) begin
            valid_d = 1'b1;
            do_d    = we_q ? '0 : ld_ext;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dmem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      m2r_q   <= 1'b0;
      regwr_q <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      rd_q    <= '0;
      do_q    <= '0;
      alu_q   <= '0;
      pc_q    <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      m2r_q   <= m2r_d;
      regwr_q <= regwr_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      rd_q    <= rd_d;
      do_q    <= do_d;
      alu_q   <= alu_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
    end
  end

  assign out_valid  = valid_q;
  assign MemtoReg_o = m2r_q;
  assign RegWr_o    = regwr_q;
  assign done_o     = done_q;
  assign misalign_o = mis_q;
  assign Rd_o       = rd_q;
  assign Do         = do_q;
  assign ALUout_o   = alu_q;
  assign PC_o       = pc_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wmask = mask_q;
  assign dmem_wdata = wdata_q;

endmodule
